// File: rtl/dro_pkg.sv
// Shared types and constants for the DRO sequencer slice.
package dro_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetP,
    StRstP,
    StCapture,
    StGuard
  } state_e;

  localparam logic OP_STORE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  localparam int unsigned IdW = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer flips to the other requester after each grant.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) begin
        gnt_o = ptr_q ? 2'b10 : 2'b01;
      end else begin
        gnt_o = req_i;
      end
    end
  end

  // A grant is always a transfer, since ready is the grant itself.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else if (|gnt_o) begin
      ptr_q <= gnt_o[0];
    end
  end

endmodule

// File: rtl/dro_sequencer.sv
// Shares one destructive-readout cell between two requesters: issues set/reset pulses with
// guard spacing and captures the readout pulse inside a bounded window.
module dro_sequencer
  import dro_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES = 2,
  parameter int unsigned READ_WINDOW  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req0_valid,
  input  logic req0_op,
  output logic req0_ready,
  input  logic req1_valid,
  input  logic req1_op,
  output logic req1_ready,
  output logic dro_set,
  output logic dro_reset,
  input  logic dro_out,
  output logic rd_valid,
  output logic rd_data,
  output logic rd_id,
  output logic held,
  output logic err_mismatch,
  output logic err_stray
);

  localparam int unsigned CntMax = (GUARD_CYCLES > READ_WINDOW) ? GUARD_CYCLES : READ_WINDOW;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] GuardLd = CntW'(GUARD_CYCLES - 1);
  localparam logic [CntW-1:0] WinLd   = CntW'(READ_WINDOW - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cap_q, cap_d;
  logic [IdW-1:0]  rid_q, rid_d;
  logic            held_d, set_d, reset_d, rdv_d, rdd_d, rdi_d, mism_d, stray_d;

  logic [1:0]      gnt;
  logic            accept;
  logic [IdW-1:0]  acc_id;
  logic            acc_op;
  logic            cap_now;

  rr_arbiter2 u_arb (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (state_q == StIdle),
    .req_i ({req1_valid, req0_valid}),
    .gnt_o (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign accept     = |gnt;
  assign acc_id     = gnt[1];
  assign acc_op     = gnt[1] ? req1_op : req0_op;
  assign cap_now    = cap_q | dro_out;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    rid_d   = rid_q;
    held_d  = held;
    set_d   = 1'b0;
    reset_d = 1'b0;
    rdv_d   = 1'b0;
    rdd_d   = rd_data;
    rdi_d   = rd_id;
    mism_d  = err_mismatch;
    // Any readout pulse outside the window, including during the reset pulse itself.
    stray_d = err_stray | (dro_out & (state_q != StCapture));

    case (state_q)
      StIdle: begin
        if (accept) begin
          rid_d = acc_id;
          if (acc_op == OP_READ) begin
            state_d = StRstP;
            reset_d = 1'b1;
          end else begin
            state_d = StSetP;
            set_d   = 1'b1;
          end
        end
      end
      StSetP: begin
        held_d  = 1'b1;
        state_d = StGuard;
        cnt_d   = GuardLd;
      end
      StRstP: begin
        cap_d   = 1'b0;
        state_d = StCapture;
        cnt_d   = WinLd;
      end
      StCapture: begin
        cap_d = cap_now;
        if (cnt_q == '0) begin
          rdv_d   = 1'b1;
          rdd_d   = cap_now;
          rdi_d   = rid_q;
          mism_d  = err_mismatch | (cap_now != held);
          held_d  = 1'b0;
          state_d = StGuard;
          cnt_d   = GuardLd;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StGuard: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      cap_q        <= 1'b0;
      rid_q        <= '0;
      held         <= 1'b0;
      dro_set      <= 1'b0;
      dro_reset    <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= 1'b0;
      rd_id        <= 1'b0;
      err_mismatch <= 1'b0;
      err_stray    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cap_q        <= cap_d;
      rid_q        <= rid_d;
      held         <= held_d;
      dro_set      <= set_d;
      dro_reset    <= reset_d;
      rd_valid     <= rdv_d;
      rd_data      <= rdd_d;
      rd_id        <= rdi_d;
      err_mismatch <= mism_d;
      err_stray    <= stray_d;
    end
  end

endmodule

// File: tb/tb_dro_sequencer.sv
// Self-checking bench for dro_sequencer: directed scenarios with a read-result scoreboard.
module tb_dro_sequencer;

  localparam int unsigned G = 2;
  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req0_valid = 1'b0, req0_op = 1'b0, req0_ready;
  logic req1_valid = 1'b0, req1_op = 1'b0, req1_ready;
  logic dro_set, dro_reset, dro_out = 1'b0;
  logic rd_valid, rd_data, rd_id, held, err_mismatch, err_stray;

  dro_sequencer #(
    .GUARD_CYCLES (G),
    .READ_WINDOW  (W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_op      (req0_op),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_op      (req1_op),
    .req1_ready   (req1_ready),
    .dro_set      (dro_set),
    .dro_reset    (dro_reset),
    .dro_out      (dro_out),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_id        (rd_id),
    .held         (held),
    .err_mismatch (err_mismatch),
    .err_stray    (err_stray)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic id;
    logic data;
    int   cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   t0      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc - t0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc - t0 < c) step();
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    dro_out    = 1'b0;
    rst        = 1'b1;
    step();
    rst = 1'b0;
    t0  = cyc;
  endtask

  task automatic store_req(input string tag, input int id);
    if (id == 0) begin req0_valid = 1'b1; req0_op = 1'b0; end
    else         begin req1_valid = 1'b1; req1_op = 1'b0; end
    #1;
    check(tag, (id == 0) ? req0_ready : req1_ready, 1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic read_req(input string tag, input int id, input bit push, input bit data);
    exp_t e;
    if (id == 0) begin req0_valid = 1'b1; req0_op = 1'b1; end
    else         begin req1_valid = 1'b1; req1_op = 1'b1; end
    #1;
    check(tag, (id == 0) ? req0_ready : req1_ready, 1);
    if (push) begin
      e.id   = (id != 0);
      e.data = data;
      e.cyc  = (cyc - t0) + 2 + W;
      sb.push_back(e);
    end
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Scoreboard side: every rd_valid must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("rd_unexpected", rd_valid, 0);
      end else begin
        mon_e = sb.pop_front();
        check("rd_cycle", cyc - t0, mon_e.cyc);
        check("rd_id", rd_id, mon_e.id);
        check("rd_data", rd_data, mon_e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    bit g;
    int gid;

    // Reset state and store-then-read.
    do_reset();
    check("rst_set", dro_set, 0);
    check("rst_reset", dro_reset, 0);
    check("rst_rdv", rd_valid, 0);
    check("rst_rdd", rd_data, 0);
    check("rst_rdid", rd_id, 0);
    check("rst_held", held, 0);
    check("rst_mism", err_mismatch, 0);
    check("rst_stray", err_stray, 0);
    check("rst_rdy0", req0_ready, 0);
    store_req("t1_store_rdy", 0);
    check("t1_set1", dro_set, 1);
    check("t1_noreset1", dro_reset, 0);
    step();
    check("t1_set2", dro_set, 0);
    check("t1_held2", held, 1);
    step();
    req0_valid = 1'b1;
    req0_op    = 1'b1;
    #1;
    check("t1_guard_rdy", req0_ready, 0);
    step();
    check("t1_read_rdy", req0_ready, 1);
    sb.push_back('{id: 1'b0, data: 1'b1, cyc: 10});
    step();
    req0_valid = 1'b0;
    check("t1_reset5", dro_reset, 1);
    check("t1_noset5", dro_set, 0);
    wait_until(8);
    dro_out = 1'b1;
    step();
    dro_out = 1'b0;
    wait_until(12);
    check("t1_mism", err_mismatch, 0);
    check("t1_stray", err_stray, 0);
    check("t1_held", held, 0);
    check("t1_drain", sb.size(), 0);

    // Read of an empty cell, from requester 1.
    do_reset();
    read_req("t2_rdy", 1, 1'b1, 1'b0);
    check("t2_reset1", dro_reset, 1);
    wait_until(8);
    check("t2_held", held, 0);
    check("t2_mism", err_mismatch, 0);
    check("t2_drain", sb.size(), 0);

    // Contention: both requesters store continuously.
    do_reset();
    req0_valid = 1'b1; req0_op = 1'b0;
    req1_valid = 1'b1; req1_op = 1'b0;
    for (int c = 0; c < 12; c++) begin
      g   = ((c % (G + 2)) == 0);
      gid = (c / (G + 2)) % 2;
      #1;
      check("cont_rdy0", req0_ready, g && (gid == 0));
      check("cont_rdy1", req1_ready, g && (gid == 1));
      check("cont_set", dro_set, (c % (G + 2)) == 1);
      check("cont_noreset", dro_reset, 0);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Errors: stray pulse while idle, then store followed by an empty read.
    do_reset();
    wait_until(2);
    dro_out = 1'b1;
    step();
    dro_out = 1'b0;
    check("t4_stray", err_stray, 1);
    store_req("t4_store_rdy", 0);
    wait_until(7);
    read_req("t4_read_rdy", 1, 1'b1, 1'b0);
    wait_until(15);
    check("t4_mism", err_mismatch, 1);
    check("t4_stray_sticky", err_stray, 1);
    check("t4_held", held, 0);
    check("t4_drain", sb.size(), 0);

    // Reset mid-read; a pulse during the reset pulse is stray.
    do_reset();
    read_req("t5_rdy", 0, 1'b0, 1'b0);
    dro_out = 1'b1;
    step();
    dro_out = 1'b0;
    check("t5_stray_rstp", err_stray, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_set", dro_set, 0);
    check("t5_reset", dro_reset, 0);
    check("t5_rdv", rd_valid, 0);
    check("t5_rdd", rd_data, 0);
    check("t5_rdid", rd_id, 0);
    check("t5_held", held, 0);
    check("t5_mism", err_mismatch, 0);
    check("t5_stray", err_stray, 0);
    store_req("t5_new_rdy", 1);
    check("t5_new_set", dro_set, 1);
    wait_until(18);
    check("t5_drain", sb.size(), 0);

    // Window edges: last capture cycle is captured, the next one is stray.
    do_reset();
    store_req("t6_store_rdy", 0);
    wait_until(4);
    read_req("t6_read1_rdy", 1, 1'b1, 1'b1);
    wait_until(4 + 1 + W);
    dro_out = 1'b1;
    step();
    dro_out = 1'b0;
    wait_until(12);
    check("t6_stray_a", err_stray, 0);
    check("t6_mism_a", err_mismatch, 0);
    read_req("t6_read2_rdy", 0, 1'b1, 1'b0);
    wait_until(12 + 2 + W);
    check("t6_stray_b", err_stray, 0);
    dro_out = 1'b1;
    step();
    dro_out = 1'b0;
    check("t6_stray_c", err_stray, 1);
    check("t6_mism_c", err_mismatch, 0);
    wait_until(24);
    check("t6_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
